// File: rtl/mobo_mem_responder.sv
// Motherboard-side memory responder for the CPU REQ/ACK read/write bus.
// Optional write-protected low region enabled by macro MOBO_RESP_PROTECT_EN.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mobo_mem_responder #(
  parameter int unsigned WORD_WIDTH  = `WORD_WIDTH,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ROM_WORDS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] cpu_ctrl,
  input  logic [WORD_WIDTH-1:0] cpu_addr,
  input  logic [WORD_WIDTH-1:0] cpu_wdata,
  output logic [WORD_WIDTH-1:0] cpu_stat,
  output logic [WORD_WIDTH-1:0] cpu_rdata
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] WAIT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  if (WAIT_CYCLES > 255) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 0..255");
  end
  if (ROM_WORDS > MEM_DEPTH) begin : g_bad_rom
    $error("ROM_WORDS must not exceed MEM_DEPTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [WORD_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic                  ack_q;
  logic                  busy_q;
  logic                  err_q;
  logic [WORD_WIDTH-1:0] rdata_q;
  logic [WORD_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic          req_c;
  logic          we_in_c;
  logic          oor_c;
  logic          prot_c;
  logic [AW-1:0] idx_c;
  logic          unused_ctrl_c;

  assign req_c         = cpu_ctrl[0];
  assign we_in_c       = cpu_ctrl[1];
  assign unused_ctrl_c = ^cpu_ctrl[WORD_WIDTH-1:2];
  assign idx_c         = addr_q[AW-1:0];

  // Full-width compare so large addresses never alias into the array.
  assign oor_c = (64'(addr_q) >= 64'(MEM_DEPTH));

`ifdef MOBO_RESP_PROTECT_EN
  assign prot_c = we_q && (64'(addr_q) < 64'(ROM_WORDS));
`else
  assign prot_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_c) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            we_q    <= we_in_c;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_ACCESS;
            end else begin
              cnt_q   <= WAIT_INIT;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_ACCESS: begin
          busy_q  <= 1'b0;
          ack_q   <= 1'b1;
          state_q <= S_DONE;
          if (oor_c) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (prot_c) begin
            err_q <= 1'b1;
          end else if (we_q) begin
            mem_q[idx_c] <= wdata_q;
          end else begin
            rdata_q <= mem_q[idx_c];
          end
        end
        S_DONE: begin
          // Completion is held until the CPU withdraws REQ.
          if (!req_c) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_stat  = {{(WORD_WIDTH-3){1'b0}}, err_q, busy_q, ack_q};
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mobo_mem_responder.sv
// Self-checking bench for mobo_mem_responder: directed vector table, hand-written
// corner sequences and randomized traffic against a memory-array reference model.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_mobo_mem_responder;

  localparam int unsigned W         = `WORD_WIDTH;
  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned ROM_WORDS = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ctrl_a, addr_a, wdata_a, stat_a, rdata_a;
  logic [W-1:0] ctrl_b, addr_b, wdata_b, stat_b, rdata_b;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mdl [longint];
  logic [W-1:0] last_rd [2];

  typedef struct {
    bit           we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    bit           exp_err;
    logic [W-1:0] exp_rd;
    bit           chk_rd;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mobo_mem_responder #(.WORD_WIDTH(W), .MEM_DEPTH(MEM_DEPTH), .WAIT_CYCLES(2), .ROM_WORDS(ROM_WORDS)) dut_a (
    .clk(clk), .rst(rst), .cpu_ctrl(ctrl_a), .cpu_addr(addr_a), .cpu_wdata(wdata_a),
    .cpu_stat(stat_a), .cpu_rdata(rdata_a)
  );

  mobo_mem_responder #(.WORD_WIDTH(W), .MEM_DEPTH(MEM_DEPTH), .WAIT_CYCLES(0), .ROM_WORDS(ROM_WORDS)) dut_b (
    .clk(clk), .rst(rst), .cpu_ctrl(ctrl_b), .cpu_addr(addr_b), .cpu_wdata(wdata_b),
    .cpu_stat(stat_b), .cpu_rdata(rdata_b)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] cur_stat(input bit b);
    return b ? stat_b : stat_a;
  endfunction

  function automatic logic [W-1:0] cur_rdata(input bit b);
    return b ? rdata_b : rdata_a;
  endfunction

  task automatic drive(input bit b, input logic [W-1:0] c, input logic [W-1:0] a, input logic [W-1:0] d);
    if (b) begin
      ctrl_b = c; addr_b = a; wdata_b = d;
    end else begin
      ctrl_a = c; addr_a = a; wdata_a = d;
    end
  endtask

  // Reference behaviour: memory image per DUT plus the last value on rdata.
  task automatic model(input bit b, input bit we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                       output bit e_err, output logic [W-1:0] e_rd, output bit chk_rd);
    longint key;
    bit oor;
    bit prot;
    key  = (longint'(b) << 40) | longint'(addr);
    oor  = (64'(addr) >= 64'(MEM_DEPTH));
    prot = 1'b0;
`ifdef MOBO_RESP_PROTECT_EN
    prot = we && (64'(addr) < 64'(ROM_WORDS));
`endif
    e_err  = oor || prot;
    chk_rd = 1'b1;
    if (oor) last_rd[b] = '0;
    else if (prot) chk_rd = 1'b0;
    else if (we) mdl[key] = wdata;
    else last_rd[b] = mdl.exists(key) ? mdl[key] : '0;
    e_rd = last_rd[b];
  endtask

  // One full handshake, entered and left at a negedge with REQ low.
  task automatic txn(input bit b, input bit we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                     input int hold, input bit e_err, input logic [W-1:0] e_rd, input bit chk_rd);
    int edges;
    int exp_lat;
    logic [W-1:0] s_ack;
    logic [W-1:0] r_ack;
    exp_lat = b ? 2 : 4;
    drive(b, W'({we, 1'b1}), addr, wdata);
    for (edges = 1; edges <= 40; edges++) begin
      @(negedge clk);
      if (edges == 1) drive(b, {W'($urandom) & ~W'(1)} | W'(1), W'($urandom), W'($urandom));
      if (cur_stat(b)[0]) break;
      check("busy_while_waiting", cur_stat(b), 64'h2);
    end
    check("ack_latency_edges", 64'(edges), 64'(exp_lat));
    s_ack = cur_stat(b);
    r_ack = cur_rdata(b);
    check("stat_at_ack", s_ack, e_err ? 64'h5 : 64'h1);
    if (chk_rd) check("rdata_at_ack", r_ack, e_rd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("stat_held", cur_stat(b), s_ack);
      check("rdata_held", cur_rdata(b), r_ack);
    end
    drive(b, '0, W'($urandom), W'($urandom));
    @(negedge clk);
    check("stat_after_drop", cur_stat(b), 64'h0);
    check("rdata_kept_idle", cur_rdata(b), r_ack);
  endtask

  task automatic txn_model(input bit b, input bit we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                           input int hold);
    bit e_err;
    bit chk_rd;
    logic [W-1:0] e_rd;
    model(b, we, addr, wdata, e_err, e_rd, chk_rd);
    txn(b, we, addr, wdata, hold, e_err, e_rd, chk_rd);
  endtask

  task automatic add_vec(input bit we, input logic [W-1:0] a, input logic [W-1:0] d,
                         input bit ee, input logic [W-1:0] er, input bit cr);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.exp_err = ee; v.exp_rd = er; v.chk_rd = cr;
    vecs.push_back(v);
  endtask

  initial begin
    bit           e_err;
    bit           chk_rd;
    logic [W-1:0] e_rd;
    int           edges;
    int           r;
    logic [W-1:0] ra;

    add_vec(1, 5,            32'hA5,       0, 32'h0,    1);
    add_vec(0, 5,            0,            0, 32'hA5,   1);
    add_vec(0, 6,            0,            0, 32'h0,    1);
    add_vec(0, 256,          0,            1, 32'h0,    1);
    add_vec(1, 32'hFFFF_FFFF, 32'h1234_5678, 1, 32'h0,  1);
    add_vec(0, 255,          0,            0, 32'h0,    1);
    add_vec(1, 255,          32'hBEEF,     0, 32'h0,    1);
    add_vec(0, 255,          0,            0, 32'hBEEF, 1);
    add_vec(1, 100,          32'h5A5A,     0, 32'hBEEF, 1);
    add_vec(0, 0,            0,            0, 32'h0,    1);
`ifdef MOBO_RESP_PROTECT_EN
    add_vec(1, 3,            32'h77,       1, 32'h0,    0);
    add_vec(0, 3,            0,            0, 32'h0,    1);
    add_vec(1, 16,           32'h77,       0, 32'h0,    1);
    add_vec(0, 16,           0,            0, 32'h77,   1);
`else
    add_vec(1, 3,            32'h77,       0, 32'h0,    1);
    add_vec(0, 3,            0,            0, 32'h77,   1);
    add_vec(1, 16,           32'h88,       0, 32'h77,   1);
    add_vec(0, 16,           0,            0, 32'h88,   1);
`endif

    rst = 1'b0;
    drive(0, '0, '0, '0);
    drive(1, '0, '0, '0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(negedge clk);
    check("reset_stat_a", stat_a, 64'h0);
    check("reset_rdata_a", rdata_a, 64'h0);
    check("reset_stat_b", stat_b, 64'h0);
    check("reset_rdata_b", rdata_b, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors on the two-wait-state instance.
    for (int i = 0; i < vecs.size(); i++) begin
      model(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, e_err, e_rd, chk_rd);
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, i % 3,
          vecs[i].exp_err, vecs[i].exp_rd, vecs[i].chk_rd);
    end

    // REQ withdrawn during WAIT: read still completes, ACK lasts one cycle, no stray write.
    model(0, 0, 5, 0, e_err, e_rd, chk_rd);
    drive(0, W'(1), 5, 0);
    @(negedge clk);
    drive(0, W'(2), 6, 32'hFF);
    for (edges = 2; edges <= 40; edges++) begin
      @(negedge clk);
      if (stat_a[0]) break;
    end
    check("drop_ack_latency", 64'(edges), 64'h4);
    check("drop_stat_ack", stat_a, 64'h1);
    check("drop_rdata", rdata_a, 64'hA5);
    drive(0, '0, '0, '0);
    @(negedge clk);
    check("drop_ack_one_cycle", stat_a, 64'h0);
    txn_model(0, 0, 6, 0, 0);

    // Reset during the wait of a write: write is abandoned.
    drive(0, W'(3), 7, 32'h33);
    @(negedge clk);
    check("midrst_busy", stat_a, 64'h2);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_stat_a", stat_a, 64'h0);
    check("midrst_rdata_a", rdata_a, 64'h0);
    check("midrst_rdata_b", rdata_b, 64'h0);
    rst = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    drive(0, '0, '0, '0);
    @(negedge clk);
    txn_model(0, 0, 7, 0, 0);

    // Zero-wait instance: back-to-back write/read of addr 9.
    txn_model(1, 1, 9, 32'h11, 0);
    txn_model(1, 0, 9, 0, 0);

    // Randomized traffic on both instances.
    for (int i = 0; i < 100; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) ra = W'($urandom_range(0, 31));
      else if (r < 8) ra = W'($urandom_range(250, 260));
      else ra = W'($urandom);
      txn_model(bit'(i % 4 == 3), bit'($urandom_range(0, 1)), ra, W'($urandom),
                $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
